// File: rtl/float_pkg.sv
// Shared definitions for the single-precision float converters.
package float_pkg;

  typedef enum logic [2:0] {
    GET_A, UNPACK, SPECIAL, ALIGN, PACK, PUT_Z
  } state_t;

  localparam int          EXP_BIAS    = 127;
  localparam logic [7:0]  EXP_SPECIAL = 8'hFF;
  localparam logic [31:0] INT_MIN     = 32'h8000_0000;
  localparam logic [31:0] INT_MAX     = 32'h7FFF_FFFF;

  function automatic logic fp32_is_nan(input logic [31:0] a);
    return (a[30:23] == EXP_SPECIAL) && (a[22:0] != 23'd0);
  endfunction

endpackage

// File: rtl/float_to_int.sv
// IEEE-754 single to signed 32-bit integer, round toward zero.
// Iterative: the mantissa is right-shifted one bit per cycle until the exponent reaches 31.
module float_to_int
  import float_pkg::*;
#(
  parameter bit SATURATE = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_a,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  output logic [31:0] output_z,
  output logic        output_z_stb,
  input  logic        output_z_ack
);

  state_t             state_q;
  logic [31:0]        a_q;
  logic [31:0]        m_q;
  logic signed [9:0]  e_q;
  logic               s_q;
  logic [31:0]        z_q;
  logic               a_ack_q;
  logic               z_stb_q;
  logic [31:0]        z_out_q;

  assign input_a_ack  = a_ack_q;
  assign output_z_stb = z_stb_q;
  assign output_z     = z_out_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= GET_A;
      a_q     <= '0;
      m_q     <= '0;
      e_q     <= '0;
      s_q     <= 1'b0;
      z_q     <= '0;
      a_ack_q <= 1'b0;
      z_stb_q <= 1'b0;
      z_out_q <= '0;
    end else begin
      case (state_q)
        GET_A: begin
          a_ack_q <= 1'b1;
          if (a_ack_q && input_a_stb) begin
            a_q     <= input_a;
            a_ack_q <= 1'b0;
            state_q <= UNPACK;
          end
        end
        UNPACK: begin
          m_q     <= {1'b1, a_q[22:0], 8'b0};
          e_q     <= 10'($signed({2'b00, a_q[30:23]}) - EXP_BIAS);
          s_q     <= a_q[31];
          state_q <= SPECIAL;
        end
        SPECIAL: begin
          if (fp32_is_nan(a_q)) begin
            z_q     <= INT_MIN;
            state_q <= PUT_Z;
          end else if (e_q < 10'sd0) begin
            z_q     <= '0;
            state_q <= PUT_Z;
          end else if (e_q == 10'sd31 && s_q && a_q[22:0] == 23'd0) begin
            // exactly -2^31 is representable; let PACK produce it
            state_q <= ALIGN;
          end else if (e_q >= 10'sd31) begin
            z_q     <= (s_q || !SATURATE) ? INT_MIN : INT_MAX;
            state_q <= PUT_Z;
          end else begin
            state_q <= ALIGN;
          end
        end
        ALIGN: begin
          if (e_q == 10'sd31) begin
            state_q <= PACK;
          end else begin
            m_q <= m_q >> 1;
            e_q <= e_q + 10'sd1;
          end
        end
        PACK: begin
          z_q     <= s_q ? (~m_q + 32'd1) : m_q;
          state_q <= PUT_Z;
        end
        PUT_Z: begin
          if (!z_stb_q) begin
            z_stb_q <= 1'b1;
            z_out_q <= z_q;
          end else if (output_z_ack) begin
            z_stb_q <= 1'b0;
            state_q <= GET_A;
          end
        end
        default: state_q <= GET_A;
      endcase
    end
  end

endmodule
